// File: rtl/alu_input_sequencer.sv
// Operand/opcode entry controller for the lab-board 4-bit ALU: debounced buttons step A -> B -> OP -> RUN.
// Optional macro ALU_SEQ_OP_CHECK_EN rejects opcode 11 in GET_OP and pulses err.

module alu_seq_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d     = {sync_q[0], btn};
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = '0;
    // counter only runs while the synchronized level disagrees with deb
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = sync_q[1];
      else                                   cnt_d = cnt_q + CW'(1);
    end
    pulse = deb_q & ~deb_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

module alu_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] op,
  output logic       start,
  output logic [1:0] stage,
  output logic       err
);
  typedef enum logic [1:0] {GET_A = 2'b00, GET_B = 2'b01, GET_OP = 2'b10, RUN = 2'b11} state_t;

  logic [1:0] btn_raw, btn_p;
  logic       enter_p, clear_p;

  assign btn_raw = {btn_clear, btn_enter};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    alu_seq_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .pulse (btn_p[i])
    );
  end

  assign enter_p = btn_p[0];
  assign clear_p = btn_p[1];

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d;
`ifdef ALU_SEQ_OP_CHECK_EN
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
`ifdef ALU_SEQ_OP_CHECK_EN
    err_d   = 1'b0;
`endif
    if (clear_p) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else if (enter_p) begin
      case (state_q)
        GET_A:  begin a_d = sw; state_d = GET_B;  end
        GET_B:  begin b_d = sw; state_d = GET_OP; end
        GET_OP: begin
`ifdef ALU_SEQ_OP_CHECK_EN
          if (sw[1:0] == 2'b11) err_d = 1'b1;
          else begin op_d = sw[1:0]; state_d = RUN; end
`else
          op_d    = sw[1:0];
          state_d = RUN;
`endif
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
`ifdef ALU_SEQ_OP_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
`ifdef ALU_SEQ_OP_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign op    = op_q;
  assign stage = state_q;
  assign start = (state_q == RUN);
`ifdef ALU_SEQ_OP_CHECK_EN
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer: directed scenarios plus a randomized run
// checked against an event-level reference model of the button paths and entry sequence.
module tb_alu_input_sequencer;
  localparam int N = 4;
`ifdef ALU_SEQ_OP_CHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic [3:0] sw = '0;
  logic [3:0] a, b;
  logic [1:0] op, stage;
  logic       start, err;

  int errors = 0;
  int checks = 0;

  alu_input_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .a(a), .b(b), .op(op), .start(start), .stage(stage), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: sync level history per button, a debounced level that flips once the
  // last N history entries all disagree with it, and the entry sequence as a step index.
  logic [1:0] m_stage;
  logic [3:0] m_a, m_b;
  logic [1:0] m_op;
  logic       m_err;
  logic       deb_e, deb_c, rose_e, rose_c, raw_e, raw_c;
  logic       hist_e[$], hist_c[$];

  function automatic bit settled(input logic q[$], input logic lvl);
    if (q.size() < N) return 1'b0;
    for (int i = q.size() - N; i < q.size(); i++) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0;
    deb_e = 0; deb_c = 0; rose_e = 0; rose_c = 0; raw_e = 0; raw_c = 0;
    hist_e.delete(); hist_c.delete();
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_err = 1'b0;
      if (rose_c) begin
        m_stage = 0; m_a = 0; m_b = 0; m_op = 0;
      end else if (rose_e) begin
        if (m_stage == 0) begin m_a = sw; m_stage = 1; end
        else if (m_stage == 1) begin m_b = sw; m_stage = 2; end
        else if (m_stage == 2) begin
          if (OPCHK && sw[1:0] == 2'b11) m_err = 1'b1;
          else begin m_op = sw[1:0]; m_stage = 3; end
        end else m_stage = 0;
      end
      rose_e = 1'b0;
      if (settled(hist_e, deb_e)) begin deb_e = ~deb_e; rose_e = deb_e; end
      rose_c = 1'b0;
      if (settled(hist_c, deb_c)) begin deb_c = ~deb_c; rose_c = deb_c; end
      hist_e.push_back(raw_e); raw_e = btn_enter;
      hist_c.push_back(raw_c); raw_c = btn_clear;
      if (hist_e.size() > N) void'(hist_e.pop_front());
      if (hist_c.size() > N) void'(hist_c.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; btn_enter = 0; btn_clear = 0;
    repeat (2) step();
    rst = 0;
  endtask

  task automatic press(input logic [3:0] v);
    sw = v; btn_enter = 1;
    repeat (8) step();
    btn_enter = 0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a, b, op, start, stage, err} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0000", {a, b, op, start, stage, err});
    end
    sw = 4'd5; btn_enter = 1;
    repeat (6) step();
    checks++;
    if (stage !== 2'b00) begin errors++; $display("FAIL early_latch: stage=%b want 00 after 6 edges", stage); end
    step();
    checks++;
    if (a !== 4'd5 || stage !== 2'b01) begin
      errors++; $display("FAIL latency7: a=%0d stage=%b want a=5 stage=01", a, stage);
    end
    btn_enter = 0;
    repeat (8) step();
  endtask

  task automatic test_full_sequence();
    do_reset();
    press(4'd9); press(4'd3); press(4'd2);
    checks++;
    if (a !== 4'd9 || b !== 4'd3 || op !== 2'b10 || start !== 1'b1 || stage !== 2'b11) begin
      errors++; $display("FAIL full_seq: a=%0d b=%0d op=%b start=%b stage=%b want 9 3 10 1 11", a, b, op, start, stage);
    end
    press(4'd0);
    checks++;
    if (start !== 1'b0 || stage !== 2'b00 || a !== 4'd9) begin
      errors++; $display("FAIL run_exit: start=%b stage=%b a=%0d want 0 00 9", start, stage, a);
    end
  endtask

  task automatic test_bounce();
    int n_tr;
    logic [1:0] prev;
    do_reset();
    n_tr = 0; prev = stage; sw = 4'd7;
    for (int i = 0; i < 30; i++) begin
      btn_enter = (i >= 20) ? 1'b1 : logic'(((i / 2) % 2) == 0);
      step();
      if (prev == 2'b00 && stage == 2'b01) n_tr++;
      prev = stage;
    end
    checks++;
    if (n_tr != 1 || stage !== 2'b01) begin
      errors++; $display("FAIL bounce: transitions=%0d stage=%b want 1 01", n_tr, stage);
    end
    btn_enter = 0;
    repeat (10) step();
    btn_enter = 1;
    repeat (3) step();
    btn_enter = 0;
    repeat (10) step();
    checks++;
    if (stage !== 2'b01 || stage !== m_stage) begin
      errors++; $display("FAIL glitch: stage=%b want 01", stage);
    end
  endtask

  task automatic test_clear_priority();
    bit start_seen;
    do_reset();
    press(4'd1); press(4'd2);
    start_seen = 0;
    btn_enter = 1; btn_clear = 1; sw = 4'd1;
    repeat (8) begin step(); if (start) start_seen = 1; end
    btn_enter = 0; btn_clear = 0;
    repeat (8) begin step(); if (start) start_seen = 1; end
    checks++;
    if (stage !== 2'b00 || {a, b, op} !== 10'h0 || start_seen) begin
      errors++; $display("FAIL clear_prio: stage=%b abop=%h start_seen=%0d want 00 000 0", stage, {a, b, op}, start_seen);
    end
  endtask

  task automatic test_op_check();
    int n_err;
    do_reset();
    press(4'd4); press(4'd6);
    n_err = 0;
    sw = 4'b0111; btn_enter = 1;
    repeat (8) begin step(); if (err) n_err++; end
    btn_enter = 0;
    repeat (8) begin step(); if (err) n_err++; end
    checks++;
    if (OPCHK) begin
      if (n_err != 1 || stage !== 2'b10 || op !== 2'b00) begin
        errors++; $display("FAIL op_reject: err_cycles=%0d stage=%b op=%b want 1 10 00", n_err, stage, op);
      end
    end else begin
      if (n_err != 0 || op !== 2'b11 || start !== 1'b1) begin
        errors++; $display("FAIL op_accept: err_cycles=%0d op=%b start=%b want 0 11 1", n_err, op, start);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    sw = 4'd12; btn_enter = 1;
    repeat (2) step();
    rst = 1;
    repeat (2) step();
    checks++;
    if ({a, b, op, start, stage, err} !== 16'h0) begin
      errors++; $display("FAIL mid_rst: got %h want 0000", {a, b, op, start, stage, err});
    end
    rst = 0;
    repeat (6) step();
    checks++;
    if (stage !== 2'b00) begin errors++; $display("FAIL mid_rst_early: stage=%b want 00", stage); end
    step();
    checks++;
    if (stage !== 2'b01 || a !== 4'd12) begin
      errors++; $display("FAIL mid_rst_event: stage=%b a=%0d want 01 12", stage, a);
    end
    repeat (20) step();
    checks++;
    if (stage !== 2'b01) begin errors++; $display("FAIL mid_rst_single: stage=%b want 01", stage); end
    btn_enter = 0;
    repeat (8) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) btn_enter = ~btn_enter;
      if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
      sw = 4'($urandom);
      step();
      checks++;
      if ({a, b, op, start, stage, err} !== {m_a, m_b, m_op, (m_stage == 2'b11), m_stage, m_err}) begin
        errors++;
        $display("FAIL random[%0d]: a=%0d b=%0d op=%b start=%b stage=%b err=%b want a=%0d b=%0d op=%b start=%b stage=%b err=%b",
                 i, a, b, op, start, stage, err, m_a, m_b, m_op, (m_stage == 2'b11), m_stage, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_sequence();
    test_bounce();
    test_clear_priority();
    test_op_check();
    test_reset_mid_debounce();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Front-end operand-entry controller for the 4-bit ALU on the lab board. It takes raw switch and push-button inputs, debounces the buttons, and steps through operand A, operand B and opcode entry. It then asserts `start` and holds `a`, `b`, `op` stable so the ALU and seven-segment output path show the result. It is the producer side of the ALU's `a`/`b`/`op`/`start` interface.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed before a button level change is accepted. Minimum 1. The board build overrides it; simulation uses the default.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `sw` input 4: value switches. Operands use `sw[3:0]`; opcode uses `sw[1:0]`.
- `btn_enter` input 1: raw enter button, active-high, asynchronous to `clk`.
- `btn_clear` input 1: raw clear button, active-high, asynchronous to `clk`.
- `a` output 4: latched operand A, to ALU.
- `b` output 4: latched operand B, to ALU.
- `op` output 2: latched opcode, to ALU. Encoding: 00 add, 01 sub, 10 mul.
- `start` output 1: high while in RUN; ALU result valid.
- `stage` output 2: current state, for LEDs. Encoding: 00 GET_A, 01 GET_B, 10 GET_OP, 11 RUN.
- `err` output 1: one-cycle pulse when an opcode entry is rejected (see Configuration).

## Operation
- Each button uses its own path: a 2-flop synchronizer, then a debouncer, then a rising-edge detector.
- Debouncer behaviour:
  - It keeps a debounced level `deb`, reset 0.
  - A counter runs while the synchronized level differs from `deb`. It clears whenever they match.
  - `deb` flips at the edge after the difference has persisted for `DEBOUNCE_CYCLES` consecutive cycles.
  - The edge detector makes a one-cycle pulse, `enter_p` or `clear_p`, the cycle after `deb` rises.
- Releasing a button produces no pulse.
- FSM transitions:
  - GET_A, on `enter_p`: `a <= sw`, go to GET_B.
  - GET_B, on `enter_p`: `b <= sw`, go to GET_OP.
  - GET_OP, on `enter_p`: `op <= sw[1:0]`, go to RUN. See Configuration for opcode 11.
  - RUN: `start` = 1. On `enter_p`, go to GET_A. `a`, `b` and `op` keep their values until overwritten.
  - Any state, on `clear_p`: `a`, `b`, `op` <= 0, go to GET_A.
- Priority: `clear_p` beats `enter_p` in the same cycle.
- `a`, `b` and `op` change only at the latch events above. They are never driven from `sw` combinationally.
- `start` is decoded from the registered state (`state == RUN`), so it is glitch-free.
- `sw` is not synchronized. Users set the switches before pressing enter, and the debounce latency guarantees they are stable at the latch edge.

## Timing
- Reset values: `a` = 0, `b` = 0, `op` = 0, `start` = 0, `stage` = 00, `err` = 0. Synchronizers, debouncers and counters are all 0.
- Latency from the first `clk` edge that samples a raw button rise to the resulting register update is `DEBOUNCE_CYCLES` + 3 edges: 2 for sync, `DEBOUNCE_CYCLES` for debounce, 1 for pulse into the FSM. With the default this is 7 edges.
- Bounce handling: a pulse shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output produces no event. A held button produces exactly one event.
- `start` rises on the edge that enters RUN and falls on the edge that leaves it.
- `err` is high for exactly the one cycle after the rejected `enter_p`.
- `rst` asserted mid-sequence, including mid-debounce: everything returns to reset values on that edge. A button still held after `rst` deasserts is debounced again from scratch and produces one event.

## Configuration
- Macro `ALU_SEQ_OP_CHECK_EN`.
- Defined: in GET_OP, `enter_p` with `sw[1:0]` == 11 does not latch `op`. State stays GET_OP and `err` pulses.
- Undefined: opcode 11 is latched and RUN is entered (the ALU outputs 0 for it). `err` is tied to 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset: assert `rst` 2 cycles -> all outputs 0, `stage` = 00. Press enter with `sw` = 5 -> after 7 edges `a` = 5, `stage` = 01.
- Full sequence: enter with `sw` = 9, 3, 2 -> `a` = 9, `b` = 3, `op` = 10, `start` = 1, `stage` = 11. One more enter -> `start` = 0, `stage` = 00, `a` = 9 retained.
- Bounce: enter toggling 1/0 every 2 cycles for 20 cycles, then held -> exactly one GET_A->GET_B transition. A 3-cycle glitch -> no transition.
- Clear priority: in GET_OP, enter and clear rise the same cycle -> `stage` = 00, `a`/`b`/`op` = 0, `start` never asserts.
- Opcode check: in GET_OP with `sw[1:0]` = 11, press enter.
  - With `ALU_SEQ_OP_CHECK_EN` defined: `err` pulses 1 cycle, `stage` stays 10.
  - Without it: `op` = 11, `start` = 1.
- Reset mid-debounce: assert `rst` 2 cycles after an enter rise, keep button held -> state 00 after reset. After `rst` deasserts, exactly one event after 7 edges.
